// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forward selects,
// multiplier FSM states and sequencing counter width.
package hazard_unit_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mul_state_e;

  // E-stage operand select; the M stage holds the younger
  // result, so it wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] wm,
    input logic       rwm,
    input logic [4:0] ww,
    input logic       rww
  );
    logic hit_m;
    logic hit_w;
    hit_m = (rs != 5'd0) && (rs == wm) && rwm;
    hit_w = (rs != 5'd0) && (rs == ww) && rww;
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit bundle: register numbers and stage
// flags in, forward selects and stall/flush controls out.
interface hazard_unit_if;
  logic [4:0] RsD;
  logic [4:0] RtD;
  logic [4:0] RsE;
  logic [4:0] RtE;
  logic [4:0] WriteRegE;
  logic [4:0] WriteRegM;
  logic [4:0] WriteRegW;
  logic       RegWriteE;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       MemtoRegE;
  logic       MemtoRegM;
  logic       BranchD;
  logic       PCSrcD;
  logic       JumpD;
  logic       MulStartE;

  logic       ForwardAD;
  logic       ForwardBD;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       MulBusy;
  logic       MulDoneE;

  modport master (
    output RsD, RtD, RsE, RtE,
    output WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW,
    output MemtoRegE, MemtoRegM,
    output BranchD, PCSrcD, JumpD, MulStartE,
    input  ForwardAD, ForwardBD,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE,
    input  MulBusy, MulDoneE
  );

  modport slave (
    input  RsD, RtD, RsE, RtE,
    input  WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW,
    input  MemtoRegE, MemtoRegM,
    input  BranchD, PCSrcD, JumpD, MulStartE,
    output ForwardAD, ForwardBD,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE,
    output FlushD, FlushE,
    output MulBusy, MulDoneE
  );
endinterface

// File: rtl/hazard_unit_mul_sequencer.sv
// Multi-cycle multiply sequencer: holds E for MUL_CYCLES-1
// cycles, then pulses done_o. Ports: clk_i, rst_i, start_i,
// stall_o (mulstall), done_o (MulDoneE).
module mul_sequencer
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic stall_o,
  output logic done_o
);

  localparam int LOAD_I = (MUL_CYCLES > 1) ?
                          MUL_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOAD_I);
  localparam logic MULTI = 1'(MUL_CYCLES > 1);

  mul_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  logic idle;
  logic busy;
  logic cnt_z;

  assign idle  = (state_q == S_IDLE);
  assign busy  = (state_q == S_BUSY);
  assign cnt_z = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && MULTI) begin
            state_q <= S_BUSY;
            cnt_q   <= LOAD;
          end
        end
        S_BUSY: begin
          // start_i is ignored here: one op at a time
          if (!cnt_z) cnt_q <= cnt_q - 1'b1;
          else        state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // The start cycle itself already stalls, so the op sees
  // MUL_CYCLES-1 stall cycles followed by one done cycle.
  assign stall_o = (idle && start_i && MULTI) ||
                   (busy && !cnt_z);

  // Single-cycle multiplies complete in the start cycle.
  assign done_o  = (busy && cnt_z) ||
                   (idle && start_i && !MULTI);

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: forwarding, load/branch/multiply stalls, flushes.
// Ports: clkH, rstH, hz (hazard_unit_if.slave); StallCount
// (32b stall-cycle counter) only with HAZARD_STALL_CNT_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic         clkH,
  input  logic         rstH,
  hazard_unit_if.slave hz
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]  StallCount
`endif
);

  logic lwstall;
  logic branchstall;
  logic mulstall;
  logic stall_fd;
  logic hit_be;
  logic hit_bm;

  assign hz.ForwardAD = (hz.RsD != 5'd0) &&
                        (hz.RsD == hz.WriteRegM) &&
                        hz.RegWriteM;
  assign hz.ForwardBD = (hz.RtD != 5'd0) &&
                        (hz.RtD == hz.WriteRegM) &&
                        hz.RegWriteM;

  assign hz.ForwardAE = fwd_sel(hz.RsE,
                                hz.WriteRegM, hz.RegWriteM,
                                hz.WriteRegW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.RtE,
                                hz.WriteRegM, hz.RegWriteM,
                                hz.WriteRegW, hz.RegWriteW);

  assign lwstall = hz.MemtoRegE &&
                   ((hz.RtE == hz.RsD) ||
                    (hz.RtE == hz.RtD));

  // Branch compares in D: wait for an ALU result still in E
  // or a load still in M.
  assign hit_be = hz.RegWriteE &&
                  ((hz.WriteRegE == hz.RsD) ||
                   (hz.WriteRegE == hz.RtD));
  assign hit_bm = hz.MemtoRegM &&
                  ((hz.WriteRegM == hz.RsD) ||
                   (hz.WriteRegM == hz.RtD));
  assign branchstall = hz.BranchD && (hit_be || hit_bm);

  mul_sequencer #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk_i   (clkH),
    .rst_i   (rstH),
    .start_i (hz.MulStartE),
    .stall_o (mulstall),
    .done_o  (hz.MulDoneE)
  );

  assign stall_fd   = lwstall || branchstall || mulstall;
  assign hz.StallF  = stall_fd;
  assign hz.StallD  = stall_fd;
  assign hz.StallE  = mulstall;
  assign hz.MulBusy = mulstall;

  // A held multiply in E must survive a D-side bubble.
  assign hz.FlushE = (lwstall || branchstall) && !mulstall;
  assign hz.FlushD = (hz.PCSrcD || hz.JumpD) && !stall_fd;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] scnt_q;
  logic [31:0] scnt_d;

  assign scnt_d = scnt_q + 32'd1;

  always_ff @(posedge clkH) begin
    if (rstH)          scnt_q <= '0;
    else if (stall_fd) scnt_q <= scnt_d;
  end

  assign StallCount = scnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, stalls, flushes,
// multiply sequencing (4-cycle and 1-cycle) and reset.
module tb_hazard_unit;

  logic clkH;
  logic rstH;
  int   n_chk;
  int   n_err;

  hazard_unit_if hz();
  hazard_unit_if hz1();

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] scnt;
  logic [31:0] scnt1;
`endif

  hazard_unit #(.MUL_CYCLES(4)) dut (
    .clkH (clkH),
    .rstH (rstH),
    .hz   (hz.slave)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .StallCount (scnt)
`endif
  );

  hazard_unit #(.MUL_CYCLES(1)) dut1 (
    .clkH (clkH),
    .rstH (rstH),
    .hz   (hz1.slave)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .StallCount (scnt1)
`endif
  );

  initial clkH = 1'b0;
  always #5 clkH = ~clkH;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkH);
    #1;
  endtask

  task automatic clr();
    hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemtoRegE = 0; hz.MemtoRegM = 0;
    hz.BranchD = 0; hz.PCSrcD = 0; hz.JumpD = 0;
    hz.MulStartE = 0;
    hz1.RsD = 0; hz1.RtD = 0; hz1.RsE = 0; hz1.RtE = 0;
    hz1.WriteRegE = 0; hz1.WriteRegM = 0; hz1.WriteRegW = 0;
    hz1.RegWriteE = 0; hz1.RegWriteM = 0; hz1.RegWriteW = 0;
    hz1.MemtoRegE = 0; hz1.MemtoRegM = 0;
    hz1.BranchD = 0; hz1.PCSrcD = 0; hz1.JumpD = 0;
    hz1.MulStartE = 0;
  endtask

  // {StallF, StallD, StallE, FlushD, FlushE}
  function automatic logic [31:0] stl();
    return {27'd0, hz.StallF, hz.StallD, hz.StallE,
            hz.FlushD, hz.FlushE};
  endfunction

  // {ForwardAD, ForwardBD, ForwardAE, ForwardBE}
  function automatic logic [31:0] fwd();
    return {26'd0, hz.ForwardAD, hz.ForwardBD,
            hz.ForwardAE, hz.ForwardBE};
  endfunction

  function automatic logic [31:0] mul();
    return {30'd0, hz.MulBusy, hz.MulDoneE};
  endfunction

  function automatic logic [31:0] mul1();
    return {30'd0, hz1.MulBusy, hz1.MulDoneE};
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    clr();
    rstH = 1'b1;
    cyc();
    cyc();
    rstH = 1'b0;
    #1;
    chk("rst_fwd", fwd(), 32'h0);
    chk("rst_stall", stl(), 32'h0);
    chk("rst_mul", mul(), 32'h0);
`ifdef HAZARD_STALL_CNT_EN
    chk("rst_scnt", scnt, 32'h0);
`endif

    // E-stage forwarding, M over W
    hz.RsE = 5; hz.WriteRegM = 5; hz.RegWriteM = 1;
    hz.WriteRegW = 5; hz.RegWriteW = 1;
    #1 chk("fae_mem", 32'(hz.ForwardAE), 32'h2);
    hz.RegWriteM = 0;
    #1 chk("fae_wb", 32'(hz.ForwardAE), 32'h1);
    hz.RsE = 0;
    #1 chk("fae_r0", 32'(hz.ForwardAE), 32'h0);
    hz.RtE = 7; hz.WriteRegW = 7;
    #1 chk("fbe_wb", 32'(hz.ForwardBE), 32'h1);
    clr();

    // D-stage comparator forwarding
    hz.RsD = 5; hz.RtD = 6; hz.WriteRegM = 5;
    hz.RegWriteM = 1;
    #1 chk("fd_a", fwd(), 32'h20);
    hz.RsD = 9; hz.WriteRegM = 6;
    #1 chk("fd_b", fwd(), 32'h10);
    hz.RsD = 0; hz.RtD = 0; hz.WriteRegM = 0;
    #1 chk("fd_r0", fwd(), 32'h0);
    clr();

    // load-use stall
    hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    #1 chk("lw_stall", stl(), 32'h19);
    cyc();
    hz.MemtoRegE = 0;
    #1 chk("lw_clear", stl(), 32'h0);
    hz.MemtoRegE = 1; hz.RsD = 2; hz.RtD = 8;
    #1 chk("lw_rtd", stl(), 32'h19);
    clr();

    // branch stall, redirect suppressed while stalled
    hz.BranchD = 1; hz.RsD = 3; hz.RegWriteE = 1;
    hz.WriteRegE = 3;
    #1 chk("br_stall", stl(), 32'h19);
    hz.PCSrcD = 1;
    #1 chk("br_noflushd", stl(), 32'h19);
    hz.RegWriteE = 0;
    #1 chk("br_flushd", stl(), 32'h2);
    hz.RtD = 4; hz.MemtoRegM = 1; hz.WriteRegM = 4;
    hz.PCSrcD = 0;
    #1 chk("br_ldm", stl(), 32'h19);
    clr();
    hz.JumpD = 1;
    #1 chk("jump", stl(), 32'h2);
    clr();

    // 4-cycle multiply, start held for 4 cycles
    cyc();
    hz.MulStartE = 1;
    #1 chk("m_c0", mul(), 32'h2);
    chk("m_c0s", stl(), 32'h1C);
    cyc();
    hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    #1 chk("m_c1", mul(), 32'h2);
    chk("m_c1_lw", stl(), 32'h1C);
    cyc();
    hz.MemtoRegE = 0; hz.RtE = 0; hz.RsD = 0;
    #1 chk("m_c2", mul(), 32'h2);
    cyc();
    #1 chk("m_c3", mul(), 32'h1);
    chk("m_c3s", stl(), 32'h0);
    cyc();
    hz.MulStartE = 0;
    #1 chk("m_c4", mul(), 32'h0);
    chk("m_c4s", stl(), 32'h0);

    // single-cycle multiply never leaves IDLE
    hz1.MulStartE = 1;
    #1 chk("m1_a", mul1(), 32'h1);
    cyc();
    #1 chk("m1_b", mul1(), 32'h1);
    hz1.MulStartE = 0;
    #1 chk("m1_off", mul1(), 32'h0);

    // reset in cycle 1 of a multiply
    cyc();
    hz.MulStartE = 1;
    #1 chk("mr_c0", mul(), 32'h2);
    cyc();
    hz.MulStartE = 0;
    rstH = 1'b1;
    #1 chk("mr_c1", mul(), 32'h2);
    cyc();
    rstH = 1'b0;
    #1 chk("mr_c2", mul(), 32'h0);
`ifdef HAZARD_STALL_CNT_EN
    chk("mr_scnt", scnt, 32'h0);
`endif
    // back in IDLE: a new start stalls immediately
    hz.MulStartE = 1;
    #1 chk("mr_idle", mul(), 32'h2);
    cyc();
    hz.MulStartE = 0;
`ifdef HAZARD_STALL_CNT_EN
    #1 chk("scnt_1", scnt, 32'h1);
`endif
    repeat (4) cyc();
    #1 chk("end_mul", mul(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 4, meaning E-stage occupancy of a multiply in cycles (legal range 1..15).
REQ-002 clkH  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rstH  in  1  synchronous, active-high reset.
REQ-004 RsD, RtD  in  5 each  decode-stage source register numbers.
REQ-005 RsE, RtE, WriteRegE  in  5 each  execute-stage source and destination register numbers.
REQ-006 WriteRegM, WriteRegW  in  5 each  memory- and writeback-stage destination register numbers.
REQ-007 RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM  in  1 each  stage write-enable and load flags.
REQ-008 BranchD, PCSrcD, JumpD  in  1 each  decode-stage branch, branch-taken and jump flags.
REQ-009 MulStartE  in  1  multiply instruction present in E.
REQ-010 ForwardAD, ForwardBD  out  1 each  decode-comparator forward select (1 = AluOutM).
REQ-011 ForwardAE, ForwardBE  out  2 each  E operand select: 00 regfile, 01 ResultW, 10 AluOutM.
REQ-012 StallF, StallD, StallE, FlushD, FlushE  out  1 each  pipeline register controls.
REQ-013 MulBusy, MulDoneE  out  1 each  multiplier sequencing status.

Function
REQ-014 ForwardAD SHALL be 1 iff RsD!=0, RsD==WriteRegM and RegWriteM; ForwardBD likewise on RtD.
REQ-015 ForwardAE SHALL be 10 if RsE!=0, RsE==WriteRegM and RegWriteM; else 01 if RsE!=0, RsE==WriteRegW and RegWriteW; else 00; ForwardBE likewise on RtE; M takes priority over W.
REQ-016 lwstall SHALL be MemtoRegE and (RtE==RsD or RtE==RtD).
REQ-017 branchstall SHALL be BranchD and ((RegWriteE and WriteRegE in {RsD,RtD}) or (MemtoRegM and WriteRegM in {RsD,RtD})).
REQ-018 FSM states IDLE and BUSY plus a 4-bit down-counter cnt SHALL sequence multiplies.
REQ-019 IDLE with MulStartE=1 and MUL_CYCLES>1: SHALL go to BUSY, load cnt=MUL_CYCLES-2; with MUL_CYCLES=1 SHALL stay IDLE and pulse MulDoneE.
REQ-020 BUSY with cnt>0: SHALL decrement cnt; BUSY with cnt==0: SHALL assert MulDoneE for that cycle and return to IDLE.
REQ-021 mulstall SHALL be 1 in the IDLE start cycle (MUL_CYCLES>1) and in BUSY while cnt>0, giving MUL_CYCLES-1 stall cycles, then one MulDoneE cycle with mulstall=0.
REQ-022 MulStartE SHALL be ignored while BUSY; no new multiply is accepted until IDLE.
REQ-023 MulBusy SHALL equal mulstall.
REQ-024 StallE SHALL equal mulstall; StallF and StallD SHALL equal lwstall or branchstall or mulstall.
REQ-025 FlushE SHALL equal (lwstall or branchstall) and not mulstall, so a held multiply is never flushed.
REQ-026 FlushD SHALL equal (PCSrcD or JumpD) and not StallD.
REQ-027 All outputs except the FSM/counter paths SHALL be combinational with zero latency.

Reset
REQ-028 rstH=1 at a clock edge SHALL force IDLE and cnt=0, including mid-multiply; MulBusy and MulDoneE SHALL be 0 the following cycle.
REQ-029 With all data inputs 0 after reset, every output SHALL be 0.

Configuration
REQ-030 Macro HAZARD_STALL_CNT_EN defined: output StallCount (32 bits) SHALL count cycles with StallF=1, reset to 0 by rstH, wrap from 0xFFFFFFFF to 0.
REQ-031 Macro undefined: StallCount port and its counter SHALL not exist; all other behaviour is identical.

Structure
REQ-032 Shared package SHALL hold the forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10), the FSM state encoding and the counter width.
REQ-033 Sub-module mul_sequencer SHALL own the FSM and counter (outputs mulstall, MulDoneE); forwarding and stall logic stay at top level.

Verification
REQ-034 RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> 01; with RsE=0 -> 00.
REQ-035 MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1, StallE=0; next cycle MemtoRegE=0 -> all 0.
REQ-036 BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> StallD=1, FlushE=1; with PCSrcD=1 and stall active, FlushD=0.
REQ-037 MUL_CYCLES=4, MulStartE=1 for 4 cycles -> StallE=1 in cycles 0-2, MulDoneE=1 in cycle 3 only, IDLE in cycle 4.
REQ-038 rstH=1 in cycle 1 of a multiply -> cycle 2 MulBusy=0, state IDLE; StallCount (macro on) reads 0.
